// File: rtl/button_event_arbiter.sv
// Button event arbiter: collects single-cycle button pulses into registered
// pending flags and presents them one at a time, round-robin, on a
// valid/ready handshake. A sticky overflow flag records merged events.
module button_event_arbiter #(
  parameter int BUTTON_WIDTH = 4,
  parameter int IDX_WIDTH    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BUTTON_WIDTH-1:0] pulse,
  input  logic                    ev_ready,
  input  logic                    ovf_clr,
  output logic                    ev_valid,
  output logic [IDX_WIDTH-1:0]    ev_idx,
  output logic [BUTTON_WIDTH-1:0] pending,
  output logic                    overflow
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  logic [0:0]              state;
  logic [0:0]              state_next;
  logic [IDX_WIDTH-1:0]    last_grant;
  logic [IDX_WIDTH-1:0]    grant_idx;
  logic                    grant_found;
  logic                    grant;
  logic [BUTTON_WIDTH-1:0] grant_mask;
  logic [BUTTON_WIDTH-1:0] pending_next;
  logic                    ovf_set;

  // Round-robin search over registered pending, starting after last_grant.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int i = 0; i < BUTTON_WIDTH; i++) begin
      int k;
      k = (int'(last_grant) + 1 + i) % BUTTON_WIDTH;
      if (!grant_found && pending[k]) begin
        grant_idx   = IDX_WIDTH'(k);
        grant_found = 1'b1;
      end
    end
  end

  // Grant decision, pending update (set wins over clear), overflow detection and next state.
  always_comb begin
    grant = 1'b0;
    if (state == IDLE)
      grant = grant_found;
    else if (ev_ready)
      grant = grant_found;

    grant_mask = '0;
    if (grant)
      grant_mask[grant_idx] = 1'b1;

    // A pulse on a still-pending bit merges, unless that bit is being granted now.
    ovf_set      = |(pulse & pending & ~grant_mask);
    pending_next = (pending & ~grant_mask) | pulse;

    state_next = state;
    case (state)
      IDLE:    if (grant_found) state_next = PRESENT;
      PRESENT: if (ev_ready && !grant_found) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered state: FSM, pending flags, presented index, round-robin pointer, overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= '0;
      ev_idx     <= '0;
      last_grant <= IDX_WIDTH'(BUTTON_WIDTH - 1);
      overflow   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state    <= state_next;
      pending  <= pending_next;
      overflow <= ovf_set | (overflow & ~ovf_clr);
      if (grant) begin
        ev_idx     <= grant_idx;
        last_grant <= grant_idx;
      end
    end
  end

  assign ev_valid = (state == PRESENT);

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with hand-computed expectations.
module tb_button_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pulse;
  logic       ev_ready;
  logic       ovf_clr;
  logic       ev_valid;
  logic [1:0] ev_idx;
  logic [3:0] pending;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  button_event_arbiter #(.BUTTON_WIDTH(4), .IDX_WIDTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .pulse    (pulse),
    .ev_ready (ev_ready),
    .ovf_clr  (ovf_clr),
    .ev_valid (ev_valid),
    .ev_idx   (ev_idx),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; outputs are observed 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check presented event (valid, idx) and pending together.
  task automatic expect_out(input string tag, input logic v, input logic [1:0] idx,
                            input logic [3:0] pend);
    check({tag, ".valid"}, 32'(ev_valid), 32'(v));
    if (v) check({tag, ".idx"}, 32'(ev_idx), 32'(idx));
    check({tag, ".pending"}, 32'(pending), 32'(pend));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pulse = 4'b1111; ev_ready = 1'b0; ovf_clr = 1'b0;

    // Reset state; pulses during reset discarded.
    step(); step();
    check("rst.valid", 32'(ev_valid), 0);
    check("rst.idx", 32'(ev_idx), 0);
    check("rst.pending", 32'(pending), 0);
    check("rst.overflow", 32'(overflow), 0);
    pulse = 4'b0000;
    rst = 1'b0;
    step();
    expect_out("rst.discard", 1'b0, 2'd0, 4'b0000);

    // Single event: pulse 0100 -> valid idx 2 two edges later, for one cycle.
    ev_ready = 1'b1;
    pulse = 4'b0100; step(); pulse = 4'b0000;
    expect_out("single.n1", 1'b0, 2'd0, 4'b0100);
    step(); expect_out("single.n2", 1'b1, 2'd2, 4'b0000);
    step(); expect_out("single.n3", 1'b0, 2'd0, 4'b0000);

    // Round-robin from fresh reset: 1111 -> 0,1,2,3 back to back.
    do_reset();
    pulse = 4'b1111; step(); pulse = 4'b0000;
    expect_out("rr.load", 1'b0, 2'd0, 4'b1111);
    step(); expect_out("rr.g0", 1'b1, 2'd0, 4'b1110);
    step(); expect_out("rr.g1", 1'b1, 2'd1, 4'b1100);
    step(); expect_out("rr.g2", 1'b1, 2'd2, 4'b1000);
    step(); expect_out("rr.g3", 1'b1, 2'd3, 4'b0000);
    step(); expect_out("rr.idle", 1'b0, 2'd0, 4'b0000);
    pulse = 4'b1001; step(); pulse = 4'b0000;
    step(); expect_out("rr2.g0", 1'b1, 2'd0, 4'b1000);
    step(); expect_out("rr2.g3", 1'b1, 2'd3, 4'b0000);
    step(); expect_out("rr2.idle", 1'b0, 2'd0, 4'b0000);

    // Backpressure: idx 1 held for 10 cycles while pulse[3] arrives.
    ev_ready = 1'b0;
    pulse = 4'b0010; step(); pulse = 4'b0000;
    step(); expect_out("bp.present", 1'b1, 2'd1, 4'b0000);
    pulse = 4'b1000; step(); pulse = 4'b0000;
    expect_out("bp.hold0", 1'b1, 2'd1, 4'b1000);
    for (int i = 1; i < 10; i++) begin
      step(); expect_out($sformatf("bp.hold%0d", i), 1'b1, 2'd1, 4'b1000);
    end
    ev_ready = 1'b1;
    step(); expect_out("bp.next", 1'b1, 2'd3, 4'b0000);
    step(); expect_out("bp.idle", 1'b0, 2'd0, 4'b0000);
    check("bp.overflow", 32'(overflow), 0);

    // Overflow: pulse[2] twice while idx 0 is stuck; single idx-2 delivery.
    ev_ready = 1'b0;
    pulse = 4'b0001; step(); pulse = 4'b0000;
    step(); expect_out("ovf.present0", 1'b1, 2'd0, 4'b0000);
    pulse = 4'b0100; step(); pulse = 4'b0000;
    check("ovf.first", 32'(overflow), 0);
    step(); step();
    pulse = 4'b0100; step(); pulse = 4'b0000;
    check("ovf.set", 32'(overflow), 1);
    check("ovf.pending", 32'(pending), 32'h4);
    ev_ready = 1'b1;
    step(); expect_out("ovf.g2", 1'b1, 2'd2, 4'b0000);
    step(); expect_out("ovf.single", 1'b0, 2'd0, 4'b0000);
    check("ovf.sticky", 32'(overflow), 1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("ovf.clr", 32'(overflow), 0);

    // ovf_clr in the same cycle as a new overflow: set wins.
    ev_ready = 1'b0;
    pulse = 4'b0001; step(); pulse = 4'b0000;
    step(); expect_out("ovfw.present0", 1'b1, 2'd0, 4'b0000);
    pulse = 4'b0010; step();
    ovf_clr = 1'b1; step(); pulse = 4'b0000;
    check("ovfw.setwins", 32'(overflow), 1);
    step(); ovf_clr = 1'b0;
    check("ovfw.cleared", 32'(overflow), 0);
    ev_ready = 1'b1;
    step(); expect_out("ovfw.g1", 1'b1, 2'd1, 4'b0000);
    step(); expect_out("ovfw.idle", 1'b0, 2'd0, 4'b0000);

    // Set-wins on pending: pulse[1] in the cycle idx 1 is granted.
    pulse = 4'b0010; step();
    expect_out("sw.load", 1'b0, 2'd0, 4'b0010);
    step(); pulse = 4'b0000;
    expect_out("sw.g1a", 1'b1, 2'd1, 4'b0010);
    check("sw.ovf", 32'(overflow), 0);
    step(); expect_out("sw.g1b", 1'b1, 2'd1, 4'b0000);
    step(); expect_out("sw.idle", 1'b0, 2'd0, 4'b0000);
    check("sw.ovf_end", 32'(overflow), 0);

    // Mid-operation reset while presenting with pending 0110.
    ev_ready = 1'b0;
    pulse = 4'b0001; step(); pulse = 4'b0000;
    step();
    pulse = 4'b0110; step(); pulse = 4'b0000;
    expect_out("mr.before", 1'b1, 2'd0, 4'b0110);
    #2 rst = 1'b1; #1;
    check("mr.valid", 32'(ev_valid), 0);
    check("mr.idx", 32'(ev_idx), 0);
    check("mr.pending", 32'(pending), 0);
    check("mr.overflow", 32'(overflow), 0);
    step(); rst = 1'b0;
    ev_ready = 1'b1;
    pulse = 4'b0001; step(); pulse = 4'b0000;
    expect_out("mr.load", 1'b0, 2'd0, 4'b0001);
    step(); expect_out("mr.g0", 1'b1, 2'd0, 4'b0000);
    step(); expect_out("mr.idle", 1'b0, 2'd0, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_event_arbiter.md
BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 Parameter BUTTON_WIDTH, default 4: number of button event sources; SHALL be 2..16.
REQ-002 Parameter IDX_WIDTH, default 2: ev_idx width; SHALL be >= ceil(log2(BUTTON_WIDTH)).
REQ-003 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 pulse  input  BUTTON_WIDTH: one-cycle event per button, already debounced and single-pulsed upstream.
REQ-006 ev_ready  input  1: consumer accepts the presented event.
REQ-007 ovf_clr  input  1: clears sticky overflow.
REQ-008 ev_valid  output  1: an event is presented on ev_idx.
REQ-009 ev_idx  output  IDX_WIDTH: index of the presented button.
REQ-010 pending  output  BUTTON_WIDTH: registered per-button pending flags.
REQ-011 overflow  output  1: sticky flag, set when an event was merged or lost.

Function
REQ-012 pending[i] SHALL be set on the edge after pulse[i]=1.
REQ-013 If pulse[i]=1 while pending[i]=1 and i is not granted that cycle, overflow SHALL set; the event merges into the pending one.
REQ-014 If pulse[i]=1 in the same cycle that i is granted, pending[i] SHALL remain 1 (set wins over clear); overflow SHALL NOT set.
REQ-015 FSM states: IDLE (ev_valid=0) and PRESENT (ev_valid=1).
REQ-016 IDLE: if pending != 0, grant one index, load ev_idx, clear its pending bit, and go to PRESENT on the same edge.
REQ-017 PRESENT with ev_ready=0: ev_idx and ev_valid SHALL hold unchanged.
REQ-018 PRESENT with ev_ready=1 and pending != 0: grant the next index and stay in PRESENT, giving back-to-back events at 1 per cycle.
REQ-019 PRESENT with ev_ready=1 and pending == 0: go to IDLE; ev_valid=0 on the next cycle.
REQ-020 Arbitration SHALL be round-robin over the registered pending. Search starts at last_grant+1, wraps modulo BUTTON_WIDTH, and the first set bit wins.
REQ-021 last_grant SHALL update only on a grant.
REQ-022 Latency: pulse at cycle n, with the block in IDLE, SHALL give ev_valid=1 at cycle n+2.
REQ-023 Arbitration SHALL use registered pending only; a pulse in cycle n is never granted in cycle n.
REQ-024 ovf_clr=1 SHALL clear overflow on the next edge. If a new overflow condition occurs in the same cycle, overflow SHALL remain 1 (set wins).
REQ-025 ev_ready while in IDLE SHALL be ignored.

Reset
REQ-026 On rst=1, asynchronously: ev_valid=0, ev_idx=0, pending=0, overflow=0, FSM=IDLE, last_grant=BUTTON_WIDTH-1 (first search starts at index 0).
REQ-027 Events arriving during reset SHALL be discarded.
REQ-028 Reset while in PRESENT SHALL drop the presented event without any handshake.
REQ-029 First grant SHALL be possible two cycles after rst deasserts.

Verification
REQ-030 Single event: pulse=0100 at cycle 5, ev_ready=1 -> ev_valid=1 with ev_idx=2 at cycle 7 only; pending=0000 afterwards.
REQ-031 Round-robin fairness: pulse=1111 in one cycle, ev_ready=1 -> ev_idx sequence 0,1,2,3 on consecutive cycles. Then pulse=1001 -> order 0,3.
REQ-032 Backpressure: event idx 1 presented, ev_ready=0 for 10 cycles while pulse[3] arrives -> ev_idx stays 1; after ev_ready=1, next event is idx 3.
REQ-033 Overflow: pulse[2] twice, 3 cycles apart, with ev_ready=0 and idx 0 presented -> overflow=1, a single idx-2 event is delivered. ovf_clr=1 -> overflow=0 next cycle.
REQ-034 Set-wins: pulse[1]=1 in the cycle idx 1 is granted -> pending[1]=1 afterwards, a second idx-1 event is delivered, overflow=0.
REQ-035 Mid-operation reset: rst pulsed while ev_valid=1 and pending=0110 -> all outputs 0 immediately. pulse=0001 two cycles after release -> ev_idx=0.
